// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One product/quotient bit per cycle; sign correction applied in a final FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             neg_res;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (count == CW'(WIDTH - 1)) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand magnitudes, one iteration step and the final sign correction
  always_comb begin
    op_signed = ~op[0];
    mag_a     = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b     = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    neg_res   = is_signed && (sign_a ^ sign_b);
    prod      = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix  = neg_res ? (~prod + (2*WIDTH)'(1)) : prod;
    quot_fix  = neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo;
    // With b==0 every step subtracts nothing, so the remainder rebuilds |a| and re-signing gives raw a
    rem_fix   = (is_signed && sign_a) ? (~acc_hi[WIDTH-1:0] + WIDTH'(1)) : acc_hi[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      is_signed   <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      opb         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count       <= '0;
            is_div      <= op[1];
            is_signed   <= op_signed;
            sign_a      <= op_signed & a[WIDTH-1];
            sign_b      <= op_signed & b[WIDTH-1];
            b_zero      <= (b == '0);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            acc_hi      <= '0;
            // mul: acc_lo = multiplier, opb = multiplicand; div: acc_lo = dividend, opb = divisor
            acc_lo      <= op[1] ? mag_a : mag_b;
            opb         <= op[1] ? mag_b : mag_a;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            hi          <= rem_fix;
            lo          <= b_zero ? acc_lo : quot_fix;
            div_by_zero <= b_zero;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit using an expected-result scoreboard queue.
module tb_muldiv_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sp;
    logic [63:0] up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    e.dbz = 1'b0;
    case (o)
      2'b00: begin sp = sx * sy; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (y == 32'd0) begin
          e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          sp = sx / sy; e.lo = sp[31:0];
          sp = sx % sy; e.hi = sp[31:0];
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Launch one op; optionally drive a start/mthi in the same cycle, or poke start+mthi mid-run
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, input bit mv);
    int n;
    int pulses;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; mthi = mv; wdata = 32'h0000_5555;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("dbz_clear_on_start", 32'(div_by_zero), 32'd0);
    n = 0;
    pulses = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      if (inject && n == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; mthi = 1'b1; wdata = 32'h0000_AAAA;
      end
      if (done) pulses++;
    end
    chk("latency", 32'(n), 32'd33);
    chk("done_after_busy", 32'(done), 32'd1);
    chk("done_pulses", 32'(pulses), 32'd1);
    e = sb.pop_front();
    chk("hi", hi, e.hi);
    chk("lo", lo, e.lo);
    chk("dbz", 32'(div_by_zero), 32'(e.dbz));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    checks = 0;
    failures = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("dbz_held", 32'(div_by_zero), 32'd1);
    run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 1'b0);
    run_op(2'b01, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);

    // start and mthi while busy are ignored; start beats a same-cycle mthi in IDLE
    run_op(2'b01, 32'h0000_0002, 32'h0000_0003, 1'b1, 1'b0);
    run_op(2'b01, 32'h0000_0004, 32'h0000_0003, 1'b0, 1'b1);

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_both", hi, 32'h0000_1234);
    chk("mtlo_both", lo, 32'h0000_1234);
    mtlo = 1'b1; wdata = 32'h0000_0077;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_only_lo", lo, 32'h0000_0077);
    chk("mtlo_only_hi", hi, 32'h0000_1234);

    // Reset mid-division aborts without a done pulse
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(ro, rx, ry, 1'b0, 1'b0);
    end

    n = sb.size();
    chk("scoreboard_empty", 32'(n), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
